// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- memory-access pipeline stage.
//
// The stage latches a load/store/writeback request from execute on start_i.
// It then runs one asynchronous-SRAM cycle: SETUP, then WAIT_CYCLES of STROBE,
// then FINISH. Byte loads are lane-aligned and sign-extended. During FINISH
// the stage presents a one-cycle register-file write.
//
// Configuration macro: MEM_UART_EN
//   Defined:   byte accesses to 0x1000_0000 (UART data) and 0x1000_0005
//              (UART status, read-only) bypass the SRAM and complete through
//              the uart_* ports. Word accesses to those addresses fault.
//   Undefined: the uart_* outputs are tied to their reset values, and every
//              address goes to the SRAM.
//
// Parameters:
//   WAIT_CYCLES  SRAM strobe width in cycles, 1..15 (default 2)
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start_i                    one-cycle request strobe, honoured only in IDLE
//   mem_rd_i, mem_wr_i         load / store request
//   mem_addr_i                 byte address
//   mem_wr_data_i              store data, already lane-shifted by execute
//   ram_be_n_i                 active-low byte enables (4'b0000 = word)
//   wb_i, wb_reg_addr_i        writeback request and destination register
//   wb_data_i                  writeback data for non-load requests
//   busy_o, done_o, fault_o    status; done/fault pulse for one cycle
//   rf_we_o, rf_waddr_o,
//   rf_wdata_o                 register-file write port (valid with done_o)
//   ram_*                      asynchronous SRAM bus
//   uart_*                     UART strobes, data and status
// ---------------------------------------------------------------------------
module mem_access #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic [3:0]  ram_be_n_i,
  input  logic        wb_i,
  input  logic [4:0]  wb_reg_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [19:0] ram_addr_o,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        ram_data_oe_o,
  output logic        ram_ce_n_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o,
  output logic [3:0]  ram_be_n_o,
  output logic        uart_rd_o,
  output logic        uart_wr_o,
  output logic [7:0]  uart_data_o,
  input  logic [7:0]  uart_data_i,
  input  logic        uart_rx_ready_i,
  input  logic        uart_tx_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_FINISH
`ifdef MEM_UART_EN
    , S_UART
`endif
  } state_t;

  // The counter loads WAIT_CYCLES-1 on entry to STROBE. STROBE therefore ends
  // on the cycle in which the counter reads zero.
  localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  cnt;

  // Request fields captured at accept time. Only the SRAM and UART paths need
  // these fields again after the accept edge.
  logic        rd_q, wr_q, byte_q, wb_q;
  logic [1:0]  lane_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;

  logic        accept, req_mem, req_fault, uart_hit;
  logic        fin_fault, fin_wb, fin_we;
  logic [4:0]  fin_waddr;
  logic [31:0] fin_wdata;

`ifdef MEM_UART_EN
  localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0005;

  logic       stat_q;
  logic [7:0] uart_status;
  assign uart_status = {2'b00, uart_tx_ready_i, 4'b0000, uart_rx_ready_i};
`endif

  function automatic logic [31:0] sext_byte(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  // A word load returns the word unchanged. A byte load selects the addressed
  // lane and sign-extends it (LB semantics).
  function automatic logic [31:0] align_load(input logic [31:0] w,
                                             input logic        is_byte,
                                             input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return is_byte ? sext_byte(b) : w;
  endfunction

  // Request classification is read straight from the execute inputs. It is
  // only meaningful in the cycle a start is accepted.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that leaves one unassigned infers a latch.
    accept    = (state == S_IDLE) && start_i;
    req_mem   = mem_rd_i || mem_wr_i;
    req_fault = (mem_rd_i && mem_wr_i) ||
                ((ram_be_n_i == 4'b0000) && (mem_addr_i[1:0] != 2'b00));
    uart_hit  = 1'b0;
`ifdef MEM_UART_EN
    uart_hit = (mem_addr_i == UART_DATA_ADDR) || (mem_addr_i == UART_STAT_ADDR);
    if (uart_hit && (ram_be_n_i == 4'b0000)) begin
      req_fault = 1'b1;
    end
`endif
  end

  // Next-state logic. It also selects what the register-file port will show
  // when the FSM enters FINISH.
  always_comb begin
    state_next = state;
    fin_fault  = 1'b0;
    fin_wb     = wb_q;
    fin_waddr  = wb_addr_q;
    fin_wdata  = wb_data_q;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          fin_wb    = wb_i;
          fin_waddr = wb_reg_addr_i;
          fin_wdata = wb_data_i;
          if (req_fault) begin
            state_next = S_FINISH;
            fin_fault  = 1'b1;
          end else if (!req_mem) begin
            state_next = S_FINISH;
          end else if (uart_hit) begin
`ifdef MEM_UART_EN
            state_next = S_UART;
`endif
          end else begin
            state_next = S_SETUP;
          end
        end
      end
      S_SETUP:  state_next = S_STROBE;
      S_STROBE: begin
        if (cnt == 4'd0) begin
          state_next = S_FINISH;
          // Read data is captured at the end of the last STROBE cycle.
          if (rd_q) fin_wdata = align_load(ram_data_i, byte_q, lane_q);
        end
      end
`ifdef MEM_UART_EN
      S_UART: begin
        state_next = S_FINISH;
        if (rd_q) fin_wdata = sext_byte(stat_q ? uart_status : uart_data_i);
      end
`endif
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    // A write to register x0 is never reported.
    fin_we = fin_wb && !fin_fault && (fin_waddr != 5'd0);
  end

  // Every output is a register. Each output is loaded from the next state, so
  // it is already valid in the first cycle of that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      byte_q        <= 1'b0;
      lane_q        <= 2'd0;
      wb_q          <= 1'b0;
      wb_addr_q     <= 5'd0;
      wb_data_q     <= 32'd0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      fault_o       <= 1'b0;
      rf_we_o       <= 1'b0;
      rf_waddr_o    <= 5'd0;
      rf_wdata_o    <= 32'd0;
      ram_addr_o    <= 20'd0;
      ram_data_o    <= 32'd0;
      ram_data_oe_o <= 1'b0;
      ram_ce_n_o    <= 1'b1;
      ram_oe_n_o    <= 1'b1;
      ram_we_n_o    <= 1'b1;
      ram_be_n_o    <= 4'b1111;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, whatever the statement order.
      state   <= state_next;
      busy_o  <= (state_next != S_IDLE);
      done_o  <= (state_next == S_FINISH);
      fault_o <= (state_next == S_FINISH) && fin_fault;
      rf_we_o <= (state_next == S_FINISH) && fin_we;
      if (state_next == S_FINISH) begin
        rf_waddr_o <= fin_waddr;
        rf_wdata_o <= fin_wdata;
      end

      if (accept) begin
        rd_q      <= mem_rd_i;
        wr_q      <= mem_wr_i;
        byte_q    <= (ram_be_n_i != 4'b0000);
        lane_q    <= mem_addr_i[1:0];
        wb_q      <= wb_i;
        wb_addr_q <= wb_reg_addr_i;
        wb_data_q <= wb_data_i;
      end

      // SETUP is entered only from an accepted start, so the inputs still
      // hold the request here.
      if (state_next == S_SETUP) begin
        ram_addr_o    <= mem_addr_i[21:2];
        ram_be_n_o    <= ram_be_n_i;
        ram_ce_n_o    <= 1'b0;
        ram_data_oe_o <= mem_wr_i;
        if (mem_wr_i) ram_data_o <= mem_wr_data_i;
      end else if (state_next == S_STROBE) begin
        ram_oe_n_o <= wr_q;
        ram_we_n_o <= !wr_q;
        cnt        <= (state == S_SETUP) ? STROBE_LAST : cnt - 4'd1;
      end else begin
        ram_ce_n_o    <= 1'b1;
        ram_oe_n_o    <= 1'b1;
        ram_we_n_o    <= 1'b1;
        ram_be_n_o    <= 4'b1111;
        ram_data_oe_o <= 1'b0;
      end
    end
  end

`ifdef MEM_UART_EN
  // UART strobes pulse in the single S_UART cycle. The status register
  // ignores writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_rd_o   <= 1'b0;
      uart_wr_o   <= 1'b0;
      uart_data_o <= 8'd0;
      stat_q      <= 1'b0;
    end else begin
      uart_rd_o <= 1'b0;
      uart_wr_o <= 1'b0;
      if (state_next == S_UART) begin
        stat_q    <= (mem_addr_i == UART_STAT_ADDR);
        uart_rd_o <= mem_rd_i && (mem_addr_i == UART_DATA_ADDR);
        if (mem_wr_i && (mem_addr_i == UART_DATA_ADDR)) begin
          uart_wr_o   <= 1'b1;
          uart_data_o <= mem_wr_data_i[7:0];
        end
      end
    end
  end
`else
  assign uart_rd_o   = 1'b0;
  assign uart_wr_o   = 1'b0;
  assign uart_data_o = 8'd0;

  // Without the UART window these inputs have no consumer.
  logic unused_uart_inputs;
  assign unused_uart_inputs = ^{mem_addr_i[31:22], uart_data_i,
                                uart_rx_ready_i, uart_tx_ready_i};
`endif

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access -- self-checking bench for mem_access.
// A behavioural SRAM device sits on the bus. A separate word array holds the
// expected memory contents and is updated from the load/store rules.
// ---------------------------------------------------------------------------
module tb_mem_access;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, mem_rd_i, mem_wr_i, wb_i;
  logic [31:0] mem_addr_i, mem_wr_data_i, wb_data_i;
  logic [3:0]  ram_be_n_i;
  logic [4:0]  wb_reg_addr_i;
  logic        busy_o, done_o, fault_o, rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [19:0] ram_addr_o;
  logic [31:0] ram_data_i, ram_data_o;
  logic        ram_data_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o;
  logic [3:0]  ram_be_n_o;
  logic        uart_rd_o, uart_wr_o;
  logic [7:0]  uart_data_o, uart_data_i;
  logic        uart_rx_ready_i, uart_tx_ready_i;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sram    [16];
  logic [31:0] exp_mem [16];

  always #5 clk = ~clk;

  mem_access #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i), .mem_wr_data_i(mem_wr_data_i),
    .ram_be_n_i(ram_be_n_i), .wb_i(wb_i), .wb_reg_addr_i(wb_reg_addr_i),
    .wb_data_i(wb_data_i), .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .ram_addr_o(ram_addr_o), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
    .ram_data_oe_o(ram_data_oe_o), .ram_ce_n_o(ram_ce_n_o),
    .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o), .ram_be_n_o(ram_be_n_o),
    .uart_rd_o(uart_rd_o), .uart_wr_o(uart_wr_o), .uart_data_o(uart_data_o),
    .uart_data_i(uart_data_i), .uart_rx_ready_i(uart_rx_ready_i),
    .uart_tx_ready_i(uart_tx_ready_i)
  );

  // Asynchronous SRAM device: read data follows the address, and the enabled
  // lanes are written on every clock edge that sees the write strobe low.
  assign ram_data_i = sram[ram_addr_o[3:0]];
  always @(posedge clk) begin
    if (!ram_ce_n_o && !ram_we_n_o) begin
      for (int i = 0; i < 4; i++)
        if (!ram_be_n_o[i]) sram[ram_addr_o[3:0]][8*i +: 8] <= ram_data_o[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and follow it cycle by cycle to done_o.
  // Expectations come from the access rules: latency, strobe widths, address,
  // register-file result and memory effect.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be_n, input logic wb,
                        input logic [4:0] wa, input logic [31:0] wbd);
    logic        is_word, fault, uart, mem, exp_we, got, seen_ce;
    logic [31:0] exp_data, word;
    logic [7:0]  b;
    int          lat, done_cyc, n_busy, n_ce, n_oe, n_we, n_doe, n_urd, n_uwr;
    logic [19:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    logic [7:0]  cap_ud;

    is_word = (be_n == 4'b0000);
    fault   = (rd && wr) || (is_word && addr[1:0] != 2'b00);
    uart    = 1'b0;
`ifdef MEM_UART_EN
    if (addr == 32'h1000_0000 || addr == 32'h1000_0005) begin
      if (is_word) fault = 1'b1;
      else         uart  = (rd || wr) && !fault;
    end
`endif
    mem      = (rd || wr) && !fault && !uart;
    lat      = mem ? 2 + W : (uart ? 2 : 1);
    exp_we   = wb && !fault && (wa != 5'd0);
    exp_data = wbd;
    if (rd && !fault) begin
      if (uart) begin
        if (addr == 32'h1000_0005) exp_data = (uart_tx_ready_i ? 32 : 0) + (uart_rx_ready_i ? 1 : 0);
        else                       b = uart_data_i;
      end else begin
        word = exp_mem[addr[5:2]];
        if (is_word) exp_data = word;
        else b = 8'((word >> (8 * addr[1:0])) & 32'hFF);
      end
      if (!is_word && !(uart && addr == 32'h1000_0005))
        exp_data = (b > 8'd127) ? (32'hFFFF_FF00 + 32'(b)) : 32'(b);
    end
    if (mem && wr) begin
      for (int i = 0; i < 4; i++)
        if (!be_n[i]) exp_mem[addr[5:2]][8*i +: 8] = wdata[8*i +: 8];
    end

    start_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr; mem_addr_i = addr;
    mem_wr_data_i = wdata; ram_be_n_i = be_n; wb_i = wb;
    wb_reg_addr_i = wa; wb_data_i = wbd;
    @(negedge clk);
    // Scramble the request inputs once the start has been accepted.
    start_i = 1'b0; mem_rd_i = $urandom; mem_wr_i = $urandom;
    mem_addr_i = $urandom; mem_wr_data_i = $urandom; ram_be_n_i = 4'($urandom);
    wb_i = $urandom; wb_reg_addr_i = 5'($urandom); wb_data_i = $urandom;

    got = 0; seen_ce = 0; done_cyc = 0;
    n_busy = 0; n_ce = 0; n_oe = 0; n_we = 0; n_doe = 0; n_urd = 0; n_uwr = 0;
    cap_addr = '0; cap_be = '1; cap_wd = '0; cap_ud = '0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      if (cyc > 1) @(negedge clk);
      n_busy += int'(busy_o);
      n_ce   += int'(!ram_ce_n_o);
      n_oe   += int'(!ram_oe_n_o);
      n_we   += int'(!ram_we_n_o);
      n_doe  += int'(ram_data_oe_o);
      n_urd  += int'(uart_rd_o);
      n_uwr  += int'(uart_wr_o);
      if (uart_wr_o) cap_ud = uart_data_o;
      if (!ram_ce_n_o && !seen_ce) begin
        seen_ce = 1; cap_addr = ram_addr_o; cap_be = ram_be_n_o;
      end
      if (!ram_we_n_o) cap_wd = ram_data_o;
      if (done_o) begin got = 1; done_cyc = cyc; end
    end

    if (!got) begin
      check({tag, " timeout"}, 32'(done_cyc), 32'(lat));
    end else begin
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(lat));
      check({tag, " fault"}, 32'(fault_o), 32'(fault));
      check({tag, " rf_we"}, 32'(rf_we_o), 32'(exp_we));
      check({tag, " rf_waddr"}, 32'(rf_waddr_o), 32'(wa));
      if (!fault && !wr) check({tag, " rf_wdata"}, rf_wdata_o, exp_data);
      check({tag, " busy_cycles"}, 32'(n_busy), 32'(lat));
      check({tag, " ce_cycles"}, 32'(n_ce), mem ? 32'(W + 1) : 0);
      check({tag, " oe_cycles"}, 32'(n_oe), (mem && rd) ? 32'(W) : 0);
      check({tag, " we_cycles"}, 32'(n_we), (mem && wr) ? 32'(W) : 0);
      check({tag, " data_oe_cycles"}, 32'(n_doe), (mem && wr) ? 32'(W + 1) : 0);
      check({tag, " uart_rd"}, 32'(n_urd), (uart && rd && addr == 32'h1000_0000) ? 1 : 0);
      check({tag, " uart_wr"}, 32'(n_uwr), (uart && wr && addr == 32'h1000_0000) ? 1 : 0);
      if (uart && wr && addr == 32'h1000_0000)
        check({tag, " uart_data"}, 32'(cap_ud), 32'(wdata[7:0]));
      if (mem) begin
        check({tag, " ram_addr"}, 32'(cap_addr), 32'(addr[21:2]));
        check({tag, " ram_be_n"}, 32'(cap_be), 32'(be_n));
        if (wr) check({tag, " ram_data"}, cap_wd, wdata);
      end
    end
    @(negedge clk);
    check({tag, " idle_after"}, {30'd0, done_o, busy_o}, 32'd0);
  endtask

  initial begin
    int unsigned kind;
    logic [31:0] a, d;
    logic [1:0]  ln;
    int          n_done, n_oe;

    rst = 1'b1; start_i = 0; mem_rd_i = 0; mem_wr_i = 0; mem_addr_i = 0;
    mem_wr_data_i = 0; ram_be_n_i = 4'hF; wb_i = 0; wb_reg_addr_i = 0; wb_data_i = 0;
    uart_data_i = 8'h9C; uart_rx_ready_i = 1'b0; uart_tx_ready_i = 1'b1;
    #2;
    check("reset status", {28'd0, busy_o, done_o, fault_o, rf_we_o}, 32'd0);
    check("reset rf", {rf_waddr_o, rf_wdata_o[26:0]} | 32'(rf_wdata_o[31:27]), 32'd0);
    check("reset strobes", {25'd0, ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_be_n_o}, 32'h7F);
    check("reset bus", {11'd0, ram_data_oe_o, ram_addr_o} | ram_data_o, 32'd0);
    check("reset uart", {22'd0, uart_rd_o, uart_wr_o, uart_data_o}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fill the SRAM with word stores; word 4 holds the reference pattern.
    for (int i = 0; i < 16; i++) begin
      d = (i == 4) ? 32'hDEAD_BEEF : $urandom;
      run_op("fill", 0, 1, 32'h8000_0000 + 32'(i * 4), d, 4'b0000, 0, 0, 0);
    end

    run_op("word_load", 1, 0, 32'h8000_0010, 0, 4'b0000, 1, 5'd5, 0);
    check("word_load data", rf_wdata_o, 32'hDEAD_BEEF);
    run_op("byte_load3", 1, 0, 32'h8000_0013, 0, 4'b0111, 1, 5'd6, 0);
    check("byte_load3 data", rf_wdata_o, 32'hFFFF_FFDE);
    run_op("byte_load2", 1, 0, 32'h8000_0012, 0, 4'b1011, 1, 5'd7, 0);
    check("byte_load2 data", rf_wdata_o, 32'hFFFF_FFAD);
    run_op("byte_store", 0, 1, 32'h8000_0011, 32'h0000_AB00, 4'b1101, 0, 5'd0, 0);
    run_op("reload", 1, 0, 32'h8000_0010, 0, 4'b0000, 1, 5'd8, 0);
    check("reload data", rf_wdata_o, 32'hDEAD_ABEF);
    run_op("misaligned", 1, 0, 32'h8000_0002, 0, 4'b0000, 1, 5'd9, 0);
    run_op("rd_and_wr", 1, 1, 32'h8000_0004, 0, 4'b0000, 1, 5'd9, 0);
    run_op("nonmem", 0, 0, 32'h0, 0, 4'hF, 1, 5'd3, 32'h1234_5678);
    run_op("x0_write", 0, 0, 32'h0, 0, 4'hF, 1, 5'd0, 32'h5555_AAAA);

    // start_i held for three cycles: only one access may happen.
    start_i = 1; mem_rd_i = 1; mem_wr_i = 0; mem_addr_i = 32'h8000_0014;
    ram_be_n_i = 4'b0000; wb_i = 1; wb_reg_addr_i = 5'd1;
    n_done = 0; n_oe = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 2) start_i = 0;
      n_done += int'(done_o);
      n_oe   += int'(!ram_oe_n_o);
    end
    check("stale_start done_pulses", 32'(n_done), 32'd1);
    check("stale_start oe_cycles", 32'(n_oe), 32'(W));

    // Reset in cycle 2 of a store aborts it before any write lands.
    start_i = 1; mem_rd_i = 0; mem_wr_i = 1; mem_addr_i = 32'h8000_0018;
    mem_wr_data_i = 32'hCAFE_F00D; ram_be_n_i = 4'b0000; wb_i = 0;
    @(negedge clk); start_i = 0;
    @(negedge clk);
    check("mid_reset we_low_before", 32'(ram_we_n_o), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_reset we_n", 32'(ram_we_n_o), 32'd1);
    check("mid_reset busy", 32'(busy_o), 32'd0);
    check("mid_reset bus", {29'd0, ram_data_oe_o, ram_ce_n_o, done_o}, 32'd2);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_op("after_reset", 1, 0, 32'h8000_0018, 0, 4'b0000, 1, 5'd2, 0);

`ifdef MEM_UART_EN
    run_op("uart_store", 0, 1, 32'h1000_0000, 32'h0000_0041, 4'b1110, 0, 5'd0, 0);
    run_op("uart_status", 1, 0, 32'h1000_0005, 0, 4'b1101, 1, 5'd4, 0);
    check("uart_status data", rf_wdata_o, 32'h0000_0020);
    run_op("uart_load", 1, 0, 32'h1000_0000, 0, 4'b1110, 1, 5'd4, 0);
    run_op("uart_word", 1, 0, 32'h1000_0000, 0, 4'b0000, 1, 5'd4, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 5);
      ln   = 2'($urandom);
      a    = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4);
      d    = $urandom;
      case (kind)
        0: run_op("rnd_wload", 1, 0, a, 0, 4'b0000, 1, 5'($urandom), 0);
        1: run_op("rnd_bload", 1, 0, a + 32'(ln), 0, ~(4'b0001 << ln), 1, 5'($urandom), 0);
        2: run_op("rnd_wstore", 0, 1, a, d, 4'b0000, 0, 5'd0, 0);
        3: run_op("rnd_bstore", 0, 1, a + 32'(ln), d, ~(4'b0001 << ln), 0, 5'd0, 0);
        4: run_op("rnd_nonmem", 0, 0, d, 0, 4'($urandom), $urandom, 5'($urandom), $urandom);
        default: begin
          if ($urandom_range(0, 1) == 1)
            run_op("rnd_rdwr", 1, 1, a, d, 4'b0000, 1, 5'($urandom), 0);
          else
            run_op("rnd_misal", 1, 0, a + 32'($urandom_range(1, 3)), 0, 4'b0000, 1, 5'($urandom), 0);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage placed directly downstream of the combinational execute stage. It latches the execute stage's memory request and writeback result on a start strobe, runs a multi-cycle asynchronous-SRAM read or write, and aligns and sign-extends byte loads. It then presents a one-cycle writeback result to the register file. With the configuration macro defined, it also routes a small MMIO window to the UART.

## Interface
- `WAIT_CYCLES`, default 2: number of cycles the SRAM strobe (`oe_n`/`we_n`) is held low; legal range 1..15.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `start_i` input 1: one-cycle request from execute. Accepted only in IDLE.
- `mem_rd_i` input 1: load request.
- `mem_wr_i` input 1: store request.
- `mem_addr_i` input 32: byte address.
- `mem_wr_data_i` input 32: store data, already lane-shifted by execute.
- `ram_be_n_i` input 4: active-low byte enables from execute. 4'b0000 means word; any other value means byte.
- `wb_i` input 1: writeback request.
- `wb_reg_addr_i` input 5: destination register.
- `wb_data_i` input 32: writeback data for non-load instructions.
- `busy_o` output 1: high from the accepted start through FINISH.
- `done_o` output 1: one-cycle completion pulse.
- `fault_o` output 1: pulses with `done_o` when the request was illegal.
- `rf_we_o` output 1: register-file write enable, valid only with `done_o`.
- `rf_waddr_o` output 5: register-file write address.
- `rf_wdata_o` output 32: register-file write data.
- `ram_addr_o` output 20: SRAM word address, equal to `mem_addr[21:2]`.
- `ram_data_i` input 32: SRAM read data.
- `ram_data_o` output 32: SRAM write data.
- `ram_data_oe_o` output 1: SRAM data-bus drive enable.
- `ram_ce_n_o`, `ram_oe_n_o`, `ram_we_n_o` output 1 each: active-low SRAM strobes.
- `ram_be_n_o` output 4: active-low SRAM byte enables.
- `uart_rd_o`, `uart_wr_o` output 1 each: one-cycle UART strobes.
- `uart_data_o` output 8: UART transmit byte.
- `uart_data_i` input 8: UART receive byte.
- `uart_rx_ready_i`, `uart_tx_ready_i` input 1 each: UART status.

## Operation
- FSM states: IDLE, SETUP, STROBE, FINISH.
- IDLE with `start_i` high: latch all `*_i` request fields, then classify the request.
  - `mem_rd_i` and `mem_wr_i` both high: illegal. Go to FINISH with `fault_o`; no bus activity; `rf_we_o`=0.
  - Word access (`ram_be_n_i`=0000) with `mem_addr[1:0]` nonzero: illegal. Go to FINISH with `fault_o`; no bus activity; `rf_we_o`=0.
  - Neither `mem_rd_i` nor `mem_wr_i`: go straight to FINISH. `rf_wdata_o`=`wb_data_i`.
  - Otherwise go to SETUP.
- SETUP, one cycle:
  - Drive `ram_addr_o`, `ram_be_n_o` and `ram_ce_n_o`=0.
  - For a store, also drive `ram_data_o` and `ram_data_oe_o`=1.
- STROBE, `WAIT_CYCLES` cycles counted by a 4-bit counter:
  - Store: `ram_we_n_o`=0.
  - Load: `ram_oe_n_o`=0, and `ram_data_i` is registered on the last STROBE cycle.
  - After the last cycle, go to FINISH.
- FINISH, one cycle:
  - `done_o`=1.
  - Strobes return high; `ram_data_oe_o`=0.
  - `rf_we_o` = latched `wb_i` AND no fault.
  - `rf_waddr_o` = latched `wb_reg_addr_i`.
  - Return to IDLE.
- Load data:
  - Word load: the registered word unchanged.
  - Byte load: select lane `mem_addr[1:0]` (0 = bits 7:0 … 3 = bits 31:24), then sign-extend bit 7 to 32 bits (LB semantics).
- Register x0: if `rf_waddr_o`=0, `rf_we_o` is forced to 0.
- `start_i` outside IDLE is ignored. No queueing.
- Reset (asynchronous, any state): go to IDLE.
  - Strobes, `ram_be_n_o`, `ram_data_oe_o`, `done_o`, `fault_o`, `rf_we_o` and `uart_*` strobes deassert immediately.
  - No partial writeback occurs.

## Timing
- Reset values:
  - `busy_o`=0, `done_o`=0, `fault_o`=0, `rf_we_o`=0.
  - `rf_waddr_o`=0, `rf_wdata_o`=0.
  - `ram_ce_n_o`=1, `ram_oe_n_o`=1, `ram_we_n_o`=1, `ram_be_n_o`=4'b1111.
  - `ram_addr_o`=0, `ram_data_o`=0, `ram_data_oe_o`=0.
  - `uart_rd_o`=0, `uart_wr_o`=0, `uart_data_o`=0.
- Let start be accepted at cycle 0. Then:
  - SRAM access: SETUP at cycle 1, STROBE at cycles 2..1+`WAIT_CYCLES`, `done_o` at cycle 2+`WAIT_CYCLES`. With the default this is cycle 4.
  - Non-memory or faulting request: `done_o` at cycle 1.
- `busy_o` is high from cycle 1 through the `done_o` cycle. A new start is accepted in the cycle after `done_o`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MEM_UART_EN` defined:
  - Address 0x1000_0000 is the UART data register.
  - Address 0x1000_0005 is the UART status register: bit5=`uart_tx_ready_i`, bit0=`uart_rx_ready_i`, other bits 0; read only.
  - Byte accesses to either address skip SETUP/STROBE. `uart_rd_o`/`uart_wr_o` pulses at cycle 1, data is sampled at cycle 1, and `done_o` occurs at cycle 2.
  - SRAM strobes stay idle.
  - A word access to the UART window faults.
- `MEM_UART_EN` undefined:
  - The UART outputs are held at their reset values.
  - These addresses go to SRAM like any other address.

## Test plan
- Word load, with the SRAM model returning 0xDEADBEEF at `mem_addr`=0x8000_0010 and `wb_reg_addr`=5:
  - `ram_addr_o`=0x00004.
  - `ram_oe_n_o` is low for cycles 2–3.
  - `done_o` at cycle 4 with `rf_we_o`=1, `rf_waddr_o`=5, `rf_wdata_o`=0xDEADBEEF.
- Byte load at 0x8000_0013 with the same data:
  - `ram_be_n_o`=0111.
  - `rf_wdata_o`=0xFFFFFFDE.
  - Repeating at 0x8000_0012 gives 0xFFFFFFAD.
- Byte store of 0x0000AB00 (lane 1, `ram_be_n_i`=1101):
  - `ram_data_oe_o` is high in cycles 1–3.
  - `ram_we_n_o` is low in cycles 2–3.
  - `done_o` at cycle 4 with `rf_we_o`=0.
- Illegal requests:
  - Word load at 0x8000_0002: `done_o` and `fault_o` at cycle 1, no strobe activity, `rf_we_o`=0.
  - `mem_rd_i` and `mem_wr_i` both high: same response.
- Stale start and mid-access reset:
  - `start_i` held high for 3 cycles: only one access occurs.
  - `rst` asserted at cycle 2 of a store: `ram_we_n_o`=1 in the same cycle and `busy_o`=0.
  - Next start runs normally.
- With `MEM_UART_EN` defined:
  - Byte store of 0x41 to 0x1000_0000: `uart_wr_o` pulses at cycle 1 with `uart_data_o`=0x41, and `done_o` at cycle 2.
  - Status read with tx=1, rx=0: `rf_wdata_o`=0x00000020.
